// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared encodings and RUN-cycle priority logic for pipeline_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int PIPE_REG_AW      = 5;
   localparam int NUM_FLUSH_STAGES = 3;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DWAIT = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef struct packed {
      logic pc;
      logic fd;
      logic de;
      logic em;
      logic mw;
   } wren_t;

   // Bit order is {fd, de, em}: youngest stage in the MSB.
   typedef logic [NUM_FLUSH_STAGES-1:0] flush_t;

   typedef struct packed {
      wren_t  wren;
      flush_t flush;
   } ctrl_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  go_dwait;
      logic  redirect;
   } run_res_t;

   function automatic run_res_t run_cycle(
      input logic redirect,
      input logic dmem_wait,
      input logic load_use,
      input logic imem_ready
   );
      run_res_t r;
      r.ctrl.wren  = 5'b11111;
      r.ctrl.flush = '0;
      r.go_dwait   = 1'b0;
      r.redirect   = 1'b0;
      if (redirect) begin
         r.ctrl.flush = '1;
         r.redirect   = 1'b1;
      end else if (dmem_wait) begin
         r.ctrl.wren = '0;
         r.go_dwait  = 1'b1;
      end else if (load_use) begin
         r.ctrl.wren.pc = 1'b0;
         r.ctrl.wren.fd = 1'b0;
         r.ctrl.flush   = 3'b010;
      end else if (!imem_ready) begin
         r.ctrl.wren.pc = 1'b0;
         r.ctrl.flush   = 3'b100;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use compare between EX load and ID reads
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_AW = PIPE_REG_AW
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              load_use
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_rd == id_rs);
      rt_match = id_uses_rt && (ex_rd == id_rt);
      // Register 0 is hard-wired, so a load into it never blocks a reader.
      load_use = ex_mem_read && (ex_rd != '0) && (rs_match || rt_match);
   end

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : stall/flush sequencing for the 5-stage pipeline with perf counters
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = PIPE_REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              mem_redirect,
   input  logic              imem_ready,
   input  logic              dmem_req,
   input  logic              dmem_ack,
   input  logic              halt_req,
   input  logic              step,
   output logic              pc_wren,
   output logic              fd_wren,
   output logic              de_wren,
   output logic              em_wren,
   output logic              mw_wren,
   output logic              fd_flush,
   output logic              de_flush,
   output logic              em_flush,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   state_e           state_q, state_d;
   logic             step_dwait_q, step_dwait_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic     load_use;
   run_res_t run_res;
   run_res_t ack_res;
   ctrl_t    ctrl;
   logic     halted_c;
   logic     count_en;
   logic     redirect_evt;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         step_dwait_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         step_dwait_q <= step_dwait_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   always_comb begin
      run_res      = run_cycle(mem_redirect, dmem_req && !dmem_ack, load_use, imem_ready);
      // On the ack cycle the memory condition is already satisfied.
      ack_res      = run_cycle(mem_redirect, 1'b0, load_use, imem_ready);
      state_d      = state_q;
      step_dwait_d = step_dwait_q;
      ctrl.wren    = '0;
      ctrl.flush   = '0;
      halted_c     = 1'b0;
      count_en     = 1'b0;
      redirect_evt = 1'b0;

      case (state_q)
         ST_INIT: begin
            ctrl.wren    = 5'b01111;
            ctrl.flush   = '1;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            ctrl         = run_res.ctrl;
            count_en     = 1'b1;
            redirect_evt = run_res.redirect;
            if (run_res.go_dwait) begin
               state_d      = ST_DWAIT;
               step_dwait_d = 1'b0;
            end else if (halt_req && !mem_redirect) begin
               state_d = ST_HALT;
            end
         end
         ST_DWAIT: begin
            count_en = 1'b1;
            if (dmem_ack) begin
               ctrl         = ack_res.ctrl;
               redirect_evt = ack_res.redirect;
               step_dwait_d = 1'b0;
               state_d      = (step_dwait_q && halt_req) ? ST_HALT : ST_RUN;
            end
         end
         ST_HALT: begin
            halted_c = 1'b1;
            if (step) begin
               ctrl = run_res.ctrl;
               if (run_res.go_dwait) begin
                  state_d      = ST_DWAIT;
                  step_dwait_d = 1'b1;
               end else if (!halt_req) begin
                  state_d = ST_RUN;
               end
            end else if (!halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (count_en && !ctrl.wren.pc && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redirect_evt && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Outputs are forced quiet for the whole time reset is held, independent of the clock.
   always_comb begin
      pc_wren  = reset_n && ctrl.wren.pc;
      fd_wren  = reset_n && ctrl.wren.fd;
      de_wren  = reset_n && ctrl.wren.de;
      em_wren  = reset_n && ctrl.wren.em;
      mw_wren  = reset_n && ctrl.wren.mw;
      fd_flush = reset_n && ctrl.flush[2];
      de_flush = reset_n && ctrl.flush[1];
      em_flush = reset_n && ctrl.flush[0];
      halted   = reset_n && halted_c;
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// tb_pipeline_ctrl : directed self-checking bench for pipeline_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rt, ex_mem_read, mem_redirect, imem_ready;
   logic        dmem_req, dmem_ack, halt_req, step;
   logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
   logic        fd_flush, de_flush, em_flush, halted;
   logic [15:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .REG_AW (5),
      .CNT_W  (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .mem_redirect (mem_redirect),
      .imem_ready   (imem_ready),
      .dmem_req     (dmem_req),
      .dmem_ack     (dmem_ack),
      .halt_req     (halt_req),
      .step         (step),
      .pc_wren      (pc_wren),
      .fd_wren      (fd_wren),
      .de_wren      (de_wren),
      .em_wren      (em_wren),
      .mw_wren      (mw_wren),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .em_flush     (em_flush),
      .halted       (halted),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Packed views: wren {pc,fd,de,em,mw}, flush {fd,de,em}.
   task automatic chk_ctrl(input string tag, input logic [4:0] wr, input logic [2:0] fl,
                           input logic hl);
      chk({tag, "_wren"},   {11'd0, pc_wren, fd_wren, de_wren, em_wren, mw_wren}, {11'd0, wr});
      chk({tag, "_flush"},  {13'd0, fd_flush, de_flush, em_flush}, {13'd0, fl});
      chk({tag, "_halted"}, {15'd0, halted}, {15'd0, hl});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      id_uses_rt = 1'b0; ex_mem_read = 1'b0; mem_redirect = 1'b0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0;
      halt_req = 1'b0; step = 1'b0;

      tick(); tick();
      chk_ctrl("reset", 5'b00000, 3'b000, 1'b0);
      chk("reset_stall_cnt", stall_cnt, 16'd0);
      chk("reset_flush_cnt", flush_cnt, 16'd0);

      reset_n = 1'b1;
      settle();
      chk_ctrl("init", 5'b01111, 3'b111, 1'b0);
      tick();
      chk_ctrl("run_first", 5'b11111, 3'b000, 1'b0);
      chk("run_first_stall_cnt", stall_cnt, 16'd0);

      // load-use on rs
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      settle();
      chk_ctrl("lu_rs", 5'b00111, 3'b010, 1'b0);
      tick();
      ex_mem_read = 1'b0;
      settle();
      chk_ctrl("lu_rs_after", 5'b11111, 3'b000, 1'b0);
      chk("lu_rs_stall_cnt", stall_cnt, 16'd1);

      // register 0 never hazards
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
      settle();
      chk_ctrl("lu_r0", 5'b11111, 3'b000, 1'b0);

      // rt matches but not used
      ex_rd = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
      settle();
      chk_ctrl("lu_rt_unused", 5'b11111, 3'b000, 1'b0);
      id_uses_rt = 1'b1;
      settle();
      chk_ctrl("lu_rt_used", 5'b00111, 3'b010, 1'b0);
      tick();
      chk("lu_rt_stall_cnt", stall_cnt, 16'd2);

      // redirect beats load-use and imem wait
      imem_ready = 1'b0; mem_redirect = 1'b1;
      settle();
      chk_ctrl("redirect", 5'b11111, 3'b111, 1'b0);
      chk("redirect_flush_cnt_pre", flush_cnt, 16'd0);
      tick();
      chk("redirect_flush_cnt", flush_cnt, 16'd1);
      chk("redirect_stall_cnt", stall_cnt, 16'd2);
      mem_redirect = 1'b0; ex_mem_read = 1'b0; id_uses_rt = 1'b0;

      // instruction fetch wait
      settle();
      chk_ctrl("imem_wait", 5'b01111, 3'b100, 1'b0);
      tick();
      chk("imem_stall_cnt", stall_cnt, 16'd3);
      imem_ready = 1'b1;

      // data memory wait: 3 frozen cycles then ack
      dmem_req = 1'b1; dmem_ack = 1'b0;
      settle();
      chk_ctrl("dwait_0", 5'b00000, 3'b000, 1'b0);
      tick();
      chk_ctrl("dwait_1", 5'b00000, 3'b000, 1'b0);
      tick();
      chk_ctrl("dwait_2", 5'b00000, 3'b000, 1'b0);
      tick();
      dmem_ack = 1'b1;
      settle();
      chk_ctrl("dwait_ack", 5'b11111, 3'b000, 1'b0);
      chk("dwait_stall_cnt", stall_cnt, 16'd6);
      tick();
      dmem_req = 1'b0; dmem_ack = 1'b0;
      settle();
      chk_ctrl("dwait_done", 5'b11111, 3'b000, 1'b0);
      chk("dwait_ack_stall_cnt", stall_cnt, 16'd6);

      // debug halt and single step
      halt_req = 1'b1;
      settle();
      chk_ctrl("halt_req_cycle", 5'b11111, 3'b000, 1'b0);
      tick();
      chk_ctrl("halted", 5'b00000, 3'b000, 1'b1);
      tick();
      chk_ctrl("halted_2", 5'b00000, 3'b000, 1'b1);
      chk("halt_stall_cnt", stall_cnt, 16'd6);
      step = 1'b1;
      settle();
      chk_ctrl("step", 5'b11111, 3'b000, 1'b1);
      tick();
      step = 1'b0;
      settle();
      chk_ctrl("step_after", 5'b00000, 3'b000, 1'b1);
      halt_req = 1'b0;
      settle();
      chk_ctrl("unhalt_cycle", 5'b00000, 3'b000, 1'b1);
      tick();
      chk_ctrl("resume", 5'b11111, 3'b000, 1'b0);
      chk("resume_stall_cnt", stall_cnt, 16'd6);

      // saturation of the stall counter
      imem_ready = 1'b0;
      repeat (16'hFFFE - 6) tick();
      chk("sat_pre", stall_cnt, 16'hFFFE);
      tick();
      chk("sat_hit", stall_cnt, 16'hFFFF);
      tick(); tick();
      chk("sat_hold", stall_cnt, 16'hFFFF);
      chk("sat_flush_cnt", flush_cnt, 16'd1);
      imem_ready = 1'b1;

      // asynchronous reset while halted
      halt_req = 1'b1;
      tick();
      chk_ctrl("halt_again", 5'b00000, 3'b000, 1'b1);
      reset_n = 1'b0;
      settle();
      chk_ctrl("reset_mid_halt", 5'b00000, 3'b000, 1'b0);
      chk("reset_mid_halt_stall_cnt", stall_cnt, 16'd0);
      chk("reset_mid_halt_flush_cnt", flush_cnt, 16'd0);
      halt_req = 1'b0;
      tick();
      reset_n = 1'b1;
      settle();
      chk_ctrl("reinit", 5'b01111, 3'b111, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
